// File: rtl/btn_pkg.sv
// Shared types and default constants for the button debouncer.
// Optional long-press detection is enabled with `BTN_LONG_PRESS_EN.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int DEF_TICK_DIV       = 100_000;
  localparam int DEF_DEBOUNCE_TICKS = 10;
  localparam int DEF_LONG_TICKS     = 1000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM and event pulses.
// `BTN_LONG_PRESS_EN adds a saturating hold counter and a long-press pulse.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
`ifdef BTN_LONG_PRESS_EN
  parameter int LONG_TICKS     = DEF_LONG_TICKS,
`endif
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
`ifdef BTN_LONG_PRESS_EN
  ,
  output logic long_o
`endif
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);

  logic [1:0]       sync_q;
  logic             s;
  btn_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             press_done;
  logic             release_done;

  // The synchronizer resets to the idle pin level so reset never looks like a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{ACTIVE_LOW}};
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

  assign s     = sync_q[1] ^ ACTIVE_LOW;
  assign cnt_d = cnt_q + CNT_W'(1);

  assign press_done   = tick_i && (state_q == PRESS_WAIT)   &&  s && (cnt_d == CNT_DONE);
  assign release_done = tick_i && (state_q == RELEASE_WAIT) && !s && (cnt_d == CNT_DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (tick_i) begin
        unique case (state_q)
          RELEASED: begin
            if (s) begin
              state_q <= PRESS_WAIT;
              cnt_q   <= CNT_W'(1);
            end
          end
          PRESS_WAIT: begin
            if (!s) begin
              state_q <= RELEASED;
              cnt_q   <= '0;
            end else if (press_done) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          PRESSED: begin
            if (!s) begin
              state_q <= RELEASE_WAIT;
              cnt_q   <= CNT_W'(1);
            end
          end
          RELEASE_WAIT: begin
            if (s) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end else if (release_done) begin
              state_q   <= RELEASED;
              cnt_q     <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          default: begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int                HOLD_W   = $clog2(LONG_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              long_q;

  assign hold_d = hold_q + HOLD_W'(1);

  // A brief bounce through RELEASE_WAIT keeps the hold time; only a real release clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (tick_i) begin
        if (press_done || release_done || (state_q == RELEASED)) begin
          hold_q <= '0;
        end else if ((state_q == PRESSED) || (state_q == RELEASE_WAIT)) begin
          if (hold_q != HOLD_MAX) begin
            hold_q <= hold_d;
            long_q <= (hold_d == HOLD_MAX);
          end
        end
      end
    end
  end

  assign long_o = long_q;
`endif

endmodule

// File: rtl/button_debouncer.sv
// N-channel push-button conditioner: shared sample-tick prescaler plus one debounce channel per pin.
// Define `BTN_LONG_PRESS_EN to add the btn_long output and per-channel hold counters.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int LONG_TICKS     = DEF_LONG_TICKS,
  parameter int BTN_ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
`ifdef BTN_LONG_PRESS_EN
  ,
  output logic [N_BTN-1:0] btn_long
`endif
);

  localparam int               DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("button_debouncer: TICK_DIV must be at least 2");
  end
  if (DEBOUNCE_TICKS < 2) begin : g_bad_debounce
    $error("button_debouncer: DEBOUNCE_TICKS must be at least 2");
  end
  if (LONG_TICKS < 1) begin : g_bad_long
    $error("button_debouncer: LONG_TICKS must be at least 1");
  end

  logic [DIV_W-1:0] div_q;
  logic             tick_q;

  // The tick is registered, so the first one appears TICK_DIV cycles after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (div_q == DIV_LAST);
      if (div_q == DIV_LAST) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
`ifdef BTN_LONG_PRESS_EN
      .LONG_TICKS    (LONG_TICKS),
`endif
      .ACTIVE_LOW    (BTN_ACTIVE_LOW != 0)
    ) u_ch (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .tick_i   (tick_q),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i])
`ifdef BTN_LONG_PRESS_EN
      ,
      .long_o   (btn_long[i])
`endif
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with N_BTN=4, TICK_DIV=10, DEBOUNCE_TICKS=4, LONG_TICKS=20.
// The long-press sequence runs only when `BTN_LONG_PRESS_EN is defined.
module tb_button_debouncer;

  localparam int NBtn      = 4;
  localparam int TickDiv   = 10;
  localparam int DebTicks  = 4;
  localparam int LongTicks = 20;

  logic            clk = 1'b0;
  logic            rstN = 1'b0;
  logic [NBtn-1:0] btnRaw = '0;
  logic [NBtn-1:0] btnLevel;
  logic [NBtn-1:0] btnPress;
  logic [NBtn-1:0] btnRelease;
`ifdef BTN_LONG_PRESS_EN
  logic [NBtn-1:0] btnLong;
`endif

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int pressCnt[NBtn];
  int relCnt[NBtn];
  int longCnt[NBtn];
  int levelHighCnt[NBtn];
  int pressAt[NBtn];
  int relAt[NBtn];
  int longAt[NBtn];

  typedef struct {
    logic [3:0] raw;
    int         ticks;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
  } vec_t;

  vec_t vecs[12];

  button_debouncer #(
    .N_BTN         (NBtn),
    .TICK_DIV      (TickDiv),
    .DEBOUNCE_TICKS(DebTicks),
    .LONG_TICKS    (LongTicks),
    .BTN_ACTIVE_LOW(0)
  ) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .btn_raw    (btnRaw),
    .btn_level  (btnLevel),
    .btn_press  (btnPress),
    .btn_release(btnRelease)
`ifdef BTN_LONG_PRESS_EN
    ,
    .btn_long   (btnLong)
`endif
  );

  always #5 clk = ~clk;

  // Event monitor: counts pulses and remembers the cycle of the latest one per channel.
  always @(posedge clk) begin
    cycle = cycle + 1;
    #1;
    for (int i = 0; i < NBtn; i++) begin
      if (btnPress[i]) begin
        pressCnt[i] = pressCnt[i] + 1;
        pressAt[i]  = cycle;
      end
      if (btnRelease[i]) begin
        relCnt[i] = relCnt[i] + 1;
        relAt[i]  = cycle;
      end
      if (btnLevel[i]) levelHighCnt[i] = levelHighCnt[i] + 1;
`ifdef BTN_LONG_PRESS_EN
      if (btnLong[i]) begin
        longCnt[i] = longCnt[i] + 1;
        longAt[i]  = cycle;
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearCounts();
    for (int i = 0; i < NBtn; i++) begin
      pressCnt[i]     = 0;
      relCnt[i]       = 0;
      longCnt[i]      = 0;
      levelHighCnt[i] = 0;
    end
  endtask

  function automatic int maskDigits(input logic [3:0] m);
    return int'(m[3]) * 1000 + int'(m[2]) * 100 + int'(m[1]) * 10 + int'(m[0]);
  endfunction

  function automatic int countDigits(input int c3, input int c2, input int c1, input int c0);
    return c3 * 1000 + c2 * 100 + c1 * 10 + c0;
  endfunction

  task automatic doReset(input logic [3:0] raw);
    @(negedge clk);
    rstN   = 1'b0;
    btnRaw = raw;
    repeat (5) @(negedge clk);
    rstN = 1'b1;
  endtask

  // Holds a pin pattern for a whole number of sample ticks.
  task automatic applyStimulus(input logic [3:0] raw, input int ticks);
    @(negedge clk);
    btnRaw = raw;
    clearCounts();
    repeat (ticks * TickDiv - 1) @(negedge clk);
  endtask

  // Counts rising edges until the chosen press bit is seen, giving 0 if the budget runs out.
  task automatic waitPress(input int ch, input int budget, output int lat);
    lat = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (btnPress[ch]) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int tickLat;
    logic [24:0] bouncePat;

    vecs[0]  = '{4'b0001, 6, 4'b0001, 4'b0001, 4'b0000};
    vecs[1]  = '{4'b0001, 3, 4'b0001, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0000, 2, 4'b0001, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b0001, 3, 4'b0001, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b0000, 6, 4'b0000, 4'b0000, 4'b0001};
    vecs[5]  = '{4'b0010, 3, 4'b0000, 4'b0000, 4'b0000};
    vecs[6]  = '{4'b0000, 3, 4'b0000, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b1100, 6, 4'b1100, 4'b1100, 4'b0000};
    vecs[8]  = '{4'b0100, 6, 4'b0100, 4'b0000, 4'b1000};
    vecs[9]  = '{4'b0110, 6, 4'b0110, 4'b0010, 4'b0000};
    vecs[10] = '{4'b1001, 6, 4'b1001, 4'b1001, 4'b0110};
    vecs[11] = '{4'b0000, 6, 4'b0000, 4'b0000, 4'b1001};
    bouncePat = 25'b1110110100111011010011101;
    clearCounts();

    $display("[TB] reset behaviour");
    btnRaw = 4'hF;
    repeat (3) @(negedge clk);
    checkOutput("resetLevel", int'(btnLevel), 0);
    checkOutput("resetPress", int'(btnPress), 0);
    checkOutput("resetRelease", int'(btnRelease), 0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    tickLat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (dut.tick_q) begin
        tickLat = k;
        break;
      end
    end
    checkOutput("firstTickCycles", tickLat, 10);

    $display("[TB] clean press latency");
    doReset(4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    btnRaw[0] = 1'b1;
    waitPress(0, 100, lat);
    checkOutput("pressLatencyInRange", int'(lat >= 33 && lat <= 43), 1);
    checkOutput("pressLatencyExact", lat, 38);
    checkOutput("levelWithPress", int'(btnLevel[0]), 1);
    @(posedge clk);
    #1;
    checkOutput("pressOneCycle", int'(btnPress[0]), 0);

    $display("[TB] vector table");
    doReset(4'b0000);
    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].raw, vecs[v].ticks);
      @(negedge clk);
      checkOutput($sformatf("vec%0d.level", v), int'(btnLevel), int'(vecs[v].level));
      checkOutput($sformatf("vec%0d.press", v),
                  countDigits(pressCnt[3], pressCnt[2], pressCnt[1], pressCnt[0]),
                  maskDigits(vecs[v].press));
      checkOutput($sformatf("vec%0d.release", v),
                  countDigits(relCnt[3], relCnt[2], relCnt[1], relCnt[0]),
                  maskDigits(vecs[v].rel));
    end

    $display("[TB] bounce on channel 1");
    clearCounts();
    for (int b = 24; b >= 0; b--) begin
      @(negedge clk);
      btnRaw[1] = bouncePat[b];
      repeat (TickDiv - 1) @(negedge clk);
    end
    @(negedge clk);
    btnRaw[1] = 1'b0;
    repeat (2 * TickDiv) @(negedge clk);
    checkOutput("bounceLevelHigh", levelHighCnt[1], 0);
    checkOutput("bouncePress", pressCnt[1], 0);
    checkOutput("bounceRelease", relCnt[1], 0);
    applyStimulus(4'b0010, 6);
    @(negedge clk);
    checkOutput("afterBouncePress", pressCnt[1], 1);
    checkOutput("afterBounceLevel", int'(btnLevel), 2);
    applyStimulus(4'b0000, 6);

    $display("[TB] simultaneous events");
    applyStimulus(4'b1100, 6);
    @(negedge clk);
    checkOutput("simPressCount", countDigits(pressCnt[3], pressCnt[2], pressCnt[1], pressCnt[0]), 1100);
    checkOutput("simPressSameCycle", pressAt[3], pressAt[2]);
    applyStimulus(4'b0000, 6);
    @(negedge clk);
    checkOutput("simReleaseCount", countDigits(relCnt[3], relCnt[2], relCnt[1], relCnt[0]), 1100);
    checkOutput("simReleaseSameCycle", relAt[3], relAt[2]);

    $display("[TB] reset while pressed");
    applyStimulus(4'b0001, 6);
    @(negedge clk);
    checkOutput("midPressLevelBefore", int'(btnLevel[0]), 1);
    rstN = 1'b0;
    clearCounts();
    #1;
    checkOutput("midPressLevelAsync", int'(btnLevel[0]), 0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    waitPress(0, 100, lat);
    checkOutput("repressLatency", lat, 41);
    checkOutput("noReleaseOnReset", relCnt[0], 0);

`ifdef BTN_LONG_PRESS_EN
    $display("[TB] long press");
    applyStimulus(4'b0000, 6);
    applyStimulus(4'b0001, 30);
    @(negedge clk);
    checkOutput("longCount", longCnt[0], 1);
    checkOutput("longDelay", longAt[0] - pressAt[0], LongTicks * TickDiv);
    applyStimulus(4'b0000, 6);
    @(negedge clk);
    checkOutput("longAfterRelease", longCnt[0], 0);
    applyStimulus(4'b0001, 30);
    @(negedge clk);
    checkOutput("longRearmed", longCnt[0], 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Input-side companion to the LED shift-register driver: conditions up to N asynchronous mechanical push-buttons into clean, clock-synchronous level and event signals. Each channel is synchronized, sampled on a shared slow tick, and debounced by a per-channel state machine, which produces a stable level plus single-cycle press and release pulses. The block sits between the board pin inputs and sandbox control logic, for example to step or freeze the LED pattern.

## Interface
- `N_BTN`, default 4: number of button channels.
- `TICK_DIV`, default 100_000: clk cycles per sample tick (1 ms at 100 MHz); legal range ≥2.
- `DEBOUNCE_TICKS`, default 10: consecutive agreeing samples required to change state; legal range ≥2.
- `LONG_TICKS`, default 1000: ticks held in PRESSED before the long-press event (used only with the macro).
- `BTN_ACTIVE_LOW`, default 0: when 1, raw pins are inverted after synchronization.
- `clk` in 1: 100 MHz system clock; only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_raw` in N_BTN: raw, asynchronous button pins.
- `btn_level` out N_BTN: debounced level, 1 = pressed.
- `btn_press` out N_BTN: one-cycle pulse on debounced press.
- `btn_release` out N_BTN: one-cycle pulse on debounced release.
- `btn_long` out N_BTN: one-cycle long-press pulse (present only with the macro).

## Operation
- Sync: a 2-flop synchronizer per channel, reset to the inactive pin value. The channel is then inverted if `BTN_ACTIVE_LOW` is set, giving `s[i]`.
- Prescaler: the counter counts 0 to TICK_DIV-1 and wraps. The registered `tick` is high for exactly one cycle per wrap. Reset clears the counter to 0, and the first tick occurs TICK_DIV cycles after reset release.
- Per-channel FSM, which advances only on cycles with `tick` high. `cnt` has width $clog2(DEBOUNCE_TICKS+1).
  - RELEASED: if s=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT: if s=1, increment cnt; when the incremented value equals DEBOUNCE_TICKS, go to PRESSED and pulse `btn_press`. If s=0, return to RELEASED with cnt=0.
  - PRESSED: if s=0, go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT: if s=0, increment cnt; at DEBOUNCE_TICKS, go to RELEASED and pulse `btn_release`. If s=1, return to PRESSED with cnt=0.
- `btn_level` = 1 in PRESSED and RELEASE_WAIT, and 0 in RELEASED and PRESS_WAIT.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- A glitch shorter than DEBOUNCE_TICKS consecutive samples never changes `btn_level` and never emits a pulse.

## Timing
- Reset values: all outputs 0, all FSMs RELEASED, all cnt 0, prescaler 0.
- Reset mid-operation: asynchronous return to the reset state. No release pulse is emitted for a button that was pressed.
- `btn_press`/`btn_release` are registered and assert in the cycle after the tick that completes the count. `btn_level` changes in that same cycle.
- Latency from a stable pin change to the pulse:
  - minimum: 2 + (DEBOUNCE_TICKS-1)·TICK_DIV + 1 cycles;
  - maximum: the minimum + TICK_DIV.
- Pulses are exactly one cycle wide. Two consecutive events on the same channel are at least DEBOUNCE_TICKS ticks apart.

## Configuration
- Macro `BTN_LONG_PRESS_EN`.
- With the macro defined:
  - a per-channel hold counter clears on entry to PRESSED and increments on each tick while the channel is in PRESSED or RELEASE_WAIT;
  - `btn_long` pulses once, for one cycle, when the counter reaches LONG_TICKS;
  - the counter then saturates, with no repeat pulse;
  - a return to RELEASED clears it.
- Without the macro: the `btn_long` port, the hold counters and the `LONG_TICKS` logic are absent. Behaviour is otherwise identical.

## Structure
- Package `btn_pkg`:
  - state enum `btn_state_e` (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - default constants for TICK_DIV, DEBOUNCE_TICKS and LONG_TICKS.
- Sub-module `btn_debounce_ch`: one channel's synchronizer, FSM and counters, driven by the shared `tick`.
- The top level holds the prescaler and a generate loop over N_BTN.
- Elaboration checks: TICK_DIV ≥ 2 and DEBOUNCE_TICKS ≥ 2.

## Test plan
All scenarios use N_BTN=4, TICK_DIV=10, DEBOUNCE_TICKS=4 and LONG_TICKS=20.
- **Reset:** hold rst_n=0 for 5 cycles with btn_raw=4'hF, then release → all outputs 0 during reset; the first `tick` occurs 10 cycles after release.
- **Clean press on btn_raw[0]:** raise it and hold → `btn_press[0]` pulses for one cycle after the 4th agreeing sample, and `btn_level[0]`=1 from that same cycle. Latency falls within the 33–43 cycle bound.
- **Bounce:** toggle btn_raw[1] high and low for 25 samples, never holding 4 consecutive samples → `btn_level[1]`=0 throughout and no pulses. A subsequent stable high produces exactly one press.
- **Simultaneous events:** press channels 2 and 3 in the same cycle, then release both → matching press pulses in the same cycle, then matching release pulses in the same cycle.
- **Reset mid-press:** assert rst_n while channel 0 is in PRESSED → `btn_level[0]` clears immediately and no release pulse is emitted. After reset is released with the pin still held, a fresh press pulse follows the full debounce time.
- **Long press (with `BTN_LONG_PRESS_EN`):** hold channel 0 for 30 ticks → one `btn_long[0]` pulse 20 ticks after entry to PRESSED and no repeat. Releasing and re-pressing re-arms it.
